lsu_bypass_window: RTL and testbench

LSU_BYPASS_WINDOW -- requirements
Module: lsu_bypass_window

---
 rtl/ariane_pkg.sv | 33 +++
 rtl/reorder_hazard_chk.sv | 22 ++
 rtl/lsu_bypass_window.sv | 160 ++++++++++++++++
 tb/tb_lsu_bypass_window.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ariane_pkg.sv
// Shared types for the issue-side reorder window: scoreboard entry, functional unit
// encoding and the per-slot window entry.
package ariane_pkg;

  typedef enum logic [2:0] {
    NONE,
    LOAD,
    STORE,
    ALU,
    CTRL_FLOW,
    MULT,
    CSR
  } fu_t;

  typedef struct packed {
    logic [31:0] pc;
    fu_t         fu;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } scoreboard_entry_t;

  typedef struct packed {
    scoreboard_entry_t sbe;
    logic              valid;
    logic              is_ctrl_flow;
  } reorder_entry_t;

  function automatic logic is_mem_op(fu_t fu);
    return (fu == LOAD) || (fu == STORE);
  endfunction

endpackage

// File: rtl/reorder_hazard_chk.sv
// Pairwise RAW/WAR/WAW check between an older and a younger scoreboard entry.
// Register fields are compared raw; x0 is deliberately not treated specially.
module reorder_hazard_chk
  import ariane_pkg::*;
(
  input  scoreboard_entry_t older_i,
  input  scoreboard_entry_t younger_i,
  output logic              hazard_o
);

  logic raw, war, waw;

  assign raw = (younger_i.rs1 == older_i.rd) || (younger_i.rs2 == older_i.rd);
  assign war = (younger_i.rd == older_i.rs1) || (younger_i.rd == older_i.rs2);
  assign waw = (younger_i.rd == older_i.rd);

  assign hazard_o = raw || war || waw;

  logic unused_fields;
  assign unused_fields = ^{older_i.pc, older_i.fu, younger_i.pc, younger_i.fu};

endmodule

// File: rtl/lsu_bypass_window.sv
// In-order issue window that lets independent non-memory ops overtake a head
// memory op stalled on the LSU. Optional perf counter: LSU_BYPASS_PERF_CNT_EN.
module lsu_bypass_window
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned MAX_BYPASS = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              debug_req_i,
  input  scoreboard_entry_t issue_entry_i,
  input  logic              issue_entry_valid_i,
  input  logic              is_ctrl_flow_i,
  output logic              issue_instr_ack_o,
  output scoreboard_entry_t issue_entry_o,
  output logic              issue_entry_valid_o,
  output logic              is_ctrl_flow_o,
  input  logic              issue_instr_ack_i,
  input  logic              lsu_ready_i
`ifdef LSU_BYPASS_PERF_CNT_EN
  ,
  output logic [31:0]       bypass_cnt_o
`endif
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  reorder_entry_t  win_q [DEPTH];
  reorder_entry_t  win_d [DEPTH];
  logic [CntW-1:0] byp_cnt_q, byp_cnt_d;
  logic            lock_q, lock_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;

  logic [CntW-1:0] occ;
  logic [CntW-1:0] tail;
  logic            cand_found;
  logic [IdxW-1:0] cand_idx;
  logic            bypass_ok;
  logic [IdxW-1:0] sel;
  logic            deq, enq;
  logic            bypass_taken;

  // haz[j][i]: entry j conflicts with older entry i (only i < j is populated)
  logic [DEPTH-1:1][DEPTH-1:0] haz;

  for (genvar j = 1; j < DEPTH; j++) begin : g_row
    for (genvar i = 0; i < DEPTH; i++) begin : g_col
      if (i < j) begin : g_chk
        reorder_hazard_chk u_chk (
          .older_i   (win_q[i].sbe),
          .younger_i (win_q[j].sbe),
          .hazard_o  (haz[j][i])
        );
      end else begin : g_none
        assign haz[j][i] = 1'b0;
      end
    end
  end

  always_comb begin
    occ = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ = occ + CntW'(win_q[k].valid);
    end
  end

  // Descending scan so the oldest qualifying entry wins
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    for (int j = DEPTH - 1; j >= 1; j--) begin
      if (win_q[j].valid && !is_mem_op(win_q[j].sbe.fu) && (win_q[j].sbe.fu != CTRL_FLOW) &&
          !(|haz[j])) begin
        cand_found = 1'b1;
        cand_idx   = IdxW'(j);
      end
    end
  end

  assign bypass_ok = win_q[0].valid && is_mem_op(win_q[0].sbe.fu) && !lsu_ready_i &&
                     !debug_req_i && (byp_cnt_q < CntW'(MAX_BYPASS)) && cand_found;

  // A presented bypass is held until consumed, unless the LSU frees up
  assign sel = (lock_q && !lsu_ready_i && !debug_req_i) ? lock_idx_q :
               (bypass_ok ? cand_idx : '0);

  assign issue_entry_valid_o = (occ != '0);
  assign issue_instr_ack_o   = (occ < CntW'(DEPTH));
  assign issue_entry_o       = issue_entry_valid_o ? win_q[sel].sbe : '0;
  assign is_ctrl_flow_o      = issue_entry_valid_o && win_q[sel].is_ctrl_flow;

  assign deq          = issue_instr_ack_i && issue_entry_valid_o;
  assign enq          = issue_entry_valid_i && issue_instr_ack_o;
  assign bypass_taken = deq && (sel != '0) && !flush_i;
  assign tail         = occ - CntW'(deq);

  always_comb begin
    win_d = win_q;
    if (deq) begin
      for (int k = 0; k < DEPTH - 1; k++) begin
        if (k >= int'(sel)) win_d[k] = win_q[k+1];
      end
      win_d[DEPTH-1] = '0;
    end
    if (enq) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (CntW'(k) == tail) begin
          win_d[k] = '{sbe: issue_entry_i, valid: 1'b1, is_ctrl_flow: is_ctrl_flow_i};
        end
      end
    end
    if (flush_i) begin
      for (int k = 0; k < DEPTH; k++) win_d[k] = '0;
    end
  end

  always_comb begin
    byp_cnt_d  = byp_cnt_q;
    lock_d     = issue_entry_valid_o && !deq && (sel != '0);
    lock_idx_d = sel;
    if (deq) byp_cnt_d = (sel != '0) ? byp_cnt_q + CntW'(1) : '0;
    if (flush_i) begin
      byp_cnt_d = '0;
      lock_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < DEPTH; k++) win_q[k] <= '0;
      byp_cnt_q  <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      win_q      <= win_d;
      byp_cnt_q  <= byp_cnt_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

`ifdef LSU_BYPASS_PERF_CNT_EN
  logic [31:0] perf_cnt_q, perf_cnt_d;

  assign perf_cnt_d   = (bypass_taken && (perf_cnt_q != '1)) ? perf_cnt_q + 32'd1 : perf_cnt_q;
  assign bypass_cnt_o = perf_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) perf_cnt_q <= '0;
    else         perf_cnt_q <= perf_cnt_d;
  end
`else
  logic unused_bypass_taken;
  assign unused_bypass_taken = bypass_taken;
`endif

endmodule

// File: tb/tb_lsu_bypass_window.sv
// Directed bench for lsu_bypass_window at DEPTH=4, MAX_BYPASS=2.
module tb_lsu_bypass_window;
  import ariane_pkg::*;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              flush_i = 1'b0;
  logic              debug_req_i = 1'b0;
  scoreboard_entry_t issue_entry_i = '0;
  logic              issue_entry_valid_i = 1'b0;
  logic              is_ctrl_flow_i = 1'b0;
  logic              issue_instr_ack_o;
  scoreboard_entry_t issue_entry_o;
  logic              issue_entry_valid_o;
  logic              is_ctrl_flow_o;
  logic              issue_instr_ack_i = 1'b0;
  logic              lsu_ready_i = 1'b0;
`ifdef LSU_BYPASS_PERF_CNT_EN
  logic [31:0]       bypass_cnt_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  lsu_bypass_window #(
    .DEPTH      (4),
    .MAX_BYPASS (2)
  ) dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .flush_i             (flush_i),
    .debug_req_i         (debug_req_i),
    .issue_entry_i       (issue_entry_i),
    .issue_entry_valid_i (issue_entry_valid_i),
    .is_ctrl_flow_i      (is_ctrl_flow_i),
    .issue_instr_ack_o   (issue_instr_ack_o),
    .issue_entry_o       (issue_entry_o),
    .issue_entry_valid_o (issue_entry_valid_o),
    .is_ctrl_flow_o      (is_ctrl_flow_o),
    .issue_instr_ack_i   (issue_instr_ack_i),
    .lsu_ready_i         (lsu_ready_i)
`ifdef LSU_BYPASS_PERF_CNT_EN
    ,
    .bypass_cnt_o        (bypass_cnt_o)
`endif
  );

  function automatic scoreboard_entry_t mk(logic [31:0] pc, fu_t fu, logic [4:0] rd,
                                           logic [4:0] rs1, logic [4:0] rs2);
    scoreboard_entry_t e;
    e.pc  = pc;
    e.fu  = fu;
    e.rd  = rd;
    e.rs1 = rs1;
    e.rs2 = rs2;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input scoreboard_entry_t e, input logic ctrl);
    issue_entry_i       = e;
    is_ctrl_flow_i      = ctrl;
    issue_entry_valid_i = 1'b1;
    tick();
    issue_entry_valid_i = 1'b0;
    is_ctrl_flow_i      = 1'b0;
  endtask

  // Consume whatever is presented for one cycle
  task automatic pop();
    issue_instr_ack_i = 1'b1;
    tick();
    issue_instr_ack_i = 1'b0;
    #1;
  endtask

  task automatic do_flush();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    #3;
    if (issue_entry_valid_o !== 1'b0) begin
      n_err++; $display("FAIL reset_valid: got %b want 0", issue_entry_valid_o);
    end
    n_vec++;
    if (issue_instr_ack_o !== 1'b1) begin
      n_err++; $display("FAIL reset_ack: got %b want 1", issue_instr_ack_o);
    end
    n_vec++;
    if (issue_entry_o !== '0) begin
      n_err++; $display("FAIL reset_entry: got %h want 0", issue_entry_o);
    end
    n_vec++;
    if (is_ctrl_flow_o !== 1'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 0", is_ctrl_flow_o);
    end
    n_vec++;
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_bypass();
    scoreboard_entry_t ld, add;
    ld  = mk(32'h100, LOAD, 5'd5, 5'd1, 5'd0);
    add = mk(32'h104, ALU,  5'd6, 5'd2, 5'd3);
    do_flush();
    lsu_ready_i = 1'b0;
    push(ld, 1'b0);
    if (issue_entry_o !== ld) begin
      n_err++; $display("FAIL byp_head_only: got %h want %h", issue_entry_o, ld);
    end
    n_vec++;
    push(add, 1'b0);
    if (issue_entry_o !== add) begin
      n_err++; $display("FAIL byp_select_add: got %h want %h", issue_entry_o, add);
    end
    n_vec++;
    lsu_ready_i = 1'b1;
    #1;
    if (issue_entry_o !== ld) begin
      n_err++; $display("FAIL byp_ready_revert: got %h want %h", issue_entry_o, ld);
    end
    n_vec++;
    lsu_ready_i = 1'b0;
    #1;
    pop();
    if (issue_entry_o !== ld || issue_entry_valid_o !== 1'b1) begin
      n_err++; $display("FAIL byp_load_next: got %h/%b want %h/1", issue_entry_o,
                        issue_entry_valid_o, ld);
    end
    n_vec++;
    lsu_ready_i = 1'b1;
    #1;
    pop();
    if (issue_entry_valid_o !== 1'b0) begin
      n_err++; $display("FAIL byp_drained: got %b want 0", issue_entry_valid_o);
    end
    n_vec++;
  endtask

  task automatic test_raw();
    scoreboard_entry_t ld, add;
    ld  = mk(32'h200, LOAD, 5'd5, 5'd1, 5'd0);
    add = mk(32'h204, ALU,  5'd6, 5'd5, 5'd3);
    do_flush();
    lsu_ready_i = 1'b0;
    push(ld, 1'b0);
    push(add, 1'b0);
    if (issue_entry_o !== ld) begin
      n_err++; $display("FAIL raw_no_bypass: got %h want %h", issue_entry_o, ld);
    end
    n_vec++;
    pop();
    if (issue_entry_o !== add) begin
      n_err++; $display("FAIL raw_add_second: got %h want %h", issue_entry_o, add);
    end
    n_vec++;
    pop();
  endtask

  task automatic test_max_bypass();
    scoreboard_entry_t st, a, b, c;
    st = mk(32'h300, STORE, 5'd0,  5'd1, 5'd2);
    a  = mk(32'h304, ALU,   5'd10, 5'd3, 5'd4);
    b  = mk(32'h308, ALU,   5'd11, 5'd3, 5'd4);
    c  = mk(32'h30c, ALU,   5'd12, 5'd3, 5'd4);
    do_flush();
    lsu_ready_i = 1'b0;
    push(st, 1'b0);
    push(a, 1'b0);
    push(b, 1'b0);
    push(c, 1'b0);
    if (issue_entry_o !== a) begin
      n_err++; $display("FAIL max_first: got %h want %h", issue_entry_o, a);
    end
    n_vec++;
    pop();
    if (issue_entry_o !== b) begin
      n_err++; $display("FAIL max_second: got %h want %h", issue_entry_o, b);
    end
    n_vec++;
    pop();
    if (issue_entry_o !== st) begin
      n_err++; $display("FAIL max_limit_store: got %h want %h", issue_entry_o, st);
    end
    n_vec++;
    pop();
    if (issue_entry_o !== c) begin
      n_err++; $display("FAIL max_third_add: got %h want %h", issue_entry_o, c);
    end
    n_vec++;
    pop();
    if (issue_entry_valid_o !== 1'b0) begin
      n_err++; $display("FAIL max_drained: got %b want 0", issue_entry_valid_o);
    end
    n_vec++;
  endtask

  task automatic test_full();
    scoreboard_entry_t e [5];
    e[0] = mk(32'h400, CTRL_FLOW, 5'd1, 5'd2, 5'd3);
    for (int i = 1; i < 5; i++) e[i] = mk(32'h400 + 32'(4 * i), ALU, 5'(8 + i), 5'd20, 5'd21);
    do_flush();
    lsu_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) push(e[i], (i == 0));
    if (issue_instr_ack_o !== 1'b0) begin
      n_err++; $display("FAIL full_ack: got %b want 0", issue_instr_ack_o);
    end
    n_vec++;
    if (is_ctrl_flow_o !== 1'b1) begin
      n_err++; $display("FAIL full_ctrl_flag: got %b want 1", is_ctrl_flow_o);
    end
    n_vec++;
    issue_entry_i       = e[4];
    issue_entry_valid_i = 1'b1;
    issue_instr_ack_i   = 1'b1;
    #1;
    if (issue_instr_ack_o !== 1'b0) begin
      n_err++; $display("FAIL full_no_comb_path: got %b want 0", issue_instr_ack_o);
    end
    n_vec++;
    tick();
    issue_entry_valid_i = 1'b0;
    issue_instr_ack_i   = 1'b0;
    #1;
    if (issue_instr_ack_o !== 1'b1) begin
      n_err++; $display("FAIL full_ack_after_pop: got %b want 1", issue_instr_ack_o);
    end
    n_vec++;
    if (issue_entry_o !== e[1] || is_ctrl_flow_o !== 1'b0) begin
      n_err++; $display("FAIL full_head_after_pop: got %h/%b want %h/0", issue_entry_o,
                        is_ctrl_flow_o, e[1]);
    end
    n_vec++;
    for (int i = 0; i < 3; i++) pop();
    if (issue_entry_valid_o !== 1'b0) begin
      n_err++; $display("FAIL full_no_fifth: got %b want 0", issue_entry_valid_o);
    end
    n_vec++;
  endtask

  task automatic test_flush();
    do_flush();
    lsu_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) push(mk(32'h500 + 32'(4 * i), ALU, 5'(1 + i), 5'd9, 5'd9), 1'b0);
    flush_i             = 1'b1;
    issue_entry_i       = mk(32'h5f0, ALU, 5'd7, 5'd8, 5'd9);
    issue_entry_valid_i = 1'b1;
    issue_instr_ack_i   = 1'b1;
    tick();
    flush_i             = 1'b0;
    issue_entry_valid_i = 1'b0;
    issue_instr_ack_i   = 1'b0;
    #1;
    if (issue_entry_valid_o !== 1'b0 || issue_instr_ack_o !== 1'b1) begin
      n_err++; $display("FAIL flush_empty: got valid %b ack %b want 0/1", issue_entry_valid_o,
                        issue_instr_ack_o);
    end
    n_vec++;
    if (issue_entry_o !== '0) begin
      n_err++; $display("FAIL flush_entry: got %h want 0", issue_entry_o);
    end
    n_vec++;
  endtask

  task automatic test_debug();
    scoreboard_entry_t ld, add;
    ld  = mk(32'h600, LOAD, 5'd5, 5'd1, 5'd0);
    add = mk(32'h604, ALU,  5'd6, 5'd2, 5'd3);
    do_flush();
    lsu_ready_i = 1'b0;
    debug_req_i = 1'b1;
    push(ld, 1'b0);
    push(add, 1'b0);
    if (issue_entry_o !== ld) begin
      n_err++; $display("FAIL dbg_in_order: got %h want %h", issue_entry_o, ld);
    end
    n_vec++;
    pop();
    if (issue_entry_o !== add) begin
      n_err++; $display("FAIL dbg_add_second: got %h want %h", issue_entry_o, add);
    end
    n_vec++;
    pop();
    debug_req_i = 1'b0;
`ifdef LSU_BYPASS_PERF_CNT_EN
    // One bypass from test_bypass, two from test_max_bypass, none since
    if (bypass_cnt_o !== 32'd3) begin
      n_err++; $display("FAIL dbg_perf_cnt: got %0d want 3", bypass_cnt_o);
    end
    n_vec++;
`endif
  endtask

  task automatic test_reset_mid();
    do_flush();
    lsu_ready_i = 1'b0;
    push(mk(32'h700, LOAD, 5'd5, 5'd1, 5'd0), 1'b0);
    push(mk(32'h704, ALU, 5'd6, 5'd2, 5'd3), 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    if (issue_entry_valid_o !== 1'b0 || issue_entry_o !== '0) begin
      n_err++; $display("FAIL midrst_async: got %b/%h want 0/0", issue_entry_valid_o,
                        issue_entry_o);
    end
    n_vec++;
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    if (issue_entry_valid_o !== 1'b0 || issue_instr_ack_o !== 1'b1) begin
      n_err++; $display("FAIL midrst_dropped: got valid %b ack %b want 0/1",
                        issue_entry_valid_o, issue_instr_ack_o);
    end
    n_vec++;
`ifdef LSU_BYPASS_PERF_CNT_EN
    if (bypass_cnt_o !== 32'd0) begin
      n_err++; $display("FAIL midrst_perf_cnt: got %0d want 0", bypass_cnt_o);
    end
    n_vec++;
`endif
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_raw();
    test_max_bypass();
    test_full();
    test_flush();
    test_debug();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
